// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - buffered UART transmitter with run-time prescaler, parity and stop-bit options
module uart_tx_cfg #(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [DATA_WIDTH-1:0]           P_DATA,
   input  logic                            Data_Valid,
   output logic                            Data_Ready,
   input  logic                            PAR_EN,
   input  logic                            PAR_TYP,
   input  logic                            STOP2,
   input  logic [PRESCALE_WIDTH-1:0]       PRESCALE,
   output logic                            TX_OUT,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr, rd_ptr;
   logic                      push, pop, shift_en;

   state_t                    state, state_n;
   logic                      loaded, loaded_n;
   logic [PRESCALE_WIDTH-1:0] pcnt, pcnt_n, prescale_q, prescale_eff;
   logic [3:0]                bcnt, bcnt_n;
   logic [DATA_WIDTH-1:0]     shift_reg, word_q;
   logic                      par_en_q, par_typ_q, stop2_q;
   logic                      tx_n, busy_n, bit_end, parity_bit;

   assign Data_Ready   = (fifo_count != CW'(FIFO_DEPTH));
   assign push         = Data_Valid & Data_Ready;
   assign prescale_eff = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
   assign bit_end      = (pcnt == prescale_q - PRESCALE_WIDTH'(1));
   assign parity_bit   = (^word_q) ^ par_typ_q;

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= P_DATA;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         loaded     <= 1'b0;
         pcnt       <= '0;
         bcnt       <= '0;
         TX_OUT     <= 1'b1;
         busy       <= 1'b0;
         shift_reg  <= '0;
         word_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         stop2_q    <= 1'b0;
         prescale_q <= PRESCALE_WIDTH'(1);
      end else begin
         state  <= state_n;
         loaded <= loaded_n;
         pcnt   <= pcnt_n;
         bcnt   <= bcnt_n;
         TX_OUT <= tx_n;
         busy   <= busy_n;
         if (pop) begin
            shift_reg  <= mem[rd_ptr];
            word_q     <= mem[rd_ptr];
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            stop2_q    <= STOP2;
            prescale_q <= prescale_eff;
         end else if (shift_en) begin
            shift_reg <= shift_reg >> 1;
         end
      end
   end

   // A pop from IDLE spends one cycle loading before START; a pop at the end of STOP starts at once.
   always_comb begin
      state_n  = state;
      loaded_n = loaded;
      pcnt_n   = bit_end ? '0 : pcnt + PRESCALE_WIDTH'(1);
      bcnt_n   = bcnt;
      tx_n     = TX_OUT;
      busy_n   = busy;
      pop      = 1'b0;
      shift_en = 1'b0;
      case (state)
         IDLE: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            pcnt_n = '0;
            bcnt_n = '0;
            if (loaded) begin
               state_n  = START;
               loaded_n = 1'b0;
               tx_n     = 1'b0;
               busy_n   = 1'b1;
            end else if (fifo_count != '0) begin
               pop      = 1'b1;
               loaded_n = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               tx_n    = shift_reg[0];
               bcnt_n  = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bcnt == 4'(DATA_WIDTH - 1)) begin
                  bcnt_n = '0;
                  if (par_en_q) begin
                     state_n = PARITY;
                     tx_n    = parity_bit;
                  end else begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  shift_en = 1'b1;
                  tx_n     = shift_reg[1];
                  bcnt_n   = bcnt + 4'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_n = STOP;
               tx_n    = 1'b1;
               bcnt_n  = '0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop2_q && bcnt == 4'd0) begin
                  bcnt_n = 4'd1;
               end else if (fifo_count != '0) begin
                  pop     = 1'b1;
                  state_n = START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
                  busy_n  = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised, buffered next-generation UART transmitter.
- Accepts words through a valid/ready handshake into an internal FIFO. Serialises them LSB-first as start, data, optional parity and 1 or 2 stop bits.
- Bit timing comes from a run-time prescaler, so no external baud-rate clock is needed.
- Sits between the system register/bus side and the TX pad, replacing the fixed 8-bit, unbuffered transmitter.

Parameters:
- DATA_WIDTH, 8: data bits per frame; legal range 5 to 9.
- FIFO_DEPTH, 4: input buffer entries; power of two, at least 2.
- PRESCALE_WIDTH, 16: width of the bit-period configuration input.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- P_DATA  input  DATA_WIDTH  word to transmit.
- Data_Valid  input  1  P_DATA is valid this cycle.
- Data_Ready  output  1  FIFO can accept a word; transfer occurs when Data_Valid and Data_Ready are both high.
- PAR_EN  input  1  parity bit enable.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- STOP2  input  1  0 = one stop bit, 1 = two stop bits.
- PRESCALE  input  PRESCALE_WIDTH  CLK cycles per bit; 0 is treated as 1.
- TX_OUT  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- fifo_count  output  clog2(FIFO_DEPTH)+1  words held in the FIFO.

Behaviour:
- Reset is synchronous and active-high; it takes effect on the CLK edge where RST is high. State after that edge:
  - TX_OUT=1, busy=0, fifo_count=0, Data_Ready=1.
  - FIFO pointers cleared; FSM in IDLE; bit and prescale counters at 0.
- RST asserted mid-frame aborts the frame: TX_OUT returns high on that edge and buffered words are discarded.
- Data_Ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
- When full, no write is accepted, even if a pop occurs in the same cycle.
- Push and pop in the same cycle when not full: fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If fifo_count != 0: pop the head word into the shift register, latch PAR_EN, PAR_TYP, STOP2 and PRESCALE (0 becomes 1), then go to START.
  - Configuration inputs changing mid-frame have no effect until the next pop.
- Bit timing:
  - Each state holds TX_OUT for exactly P_latched cycles, counted by the prescale counter (0 to P-1).
  - The transition happens on the edge where the counter reaches P-1.
- START: TX_OUT=0; then go to DATA.
- DATA:
  - TX_OUT = shift_reg[0]; the register shifts right at each bit end.
  - After DATA_WIDTH bits, go to PARITY if PAR_EN is latched, else STOP.
- PARITY: TX_OUT = (^word) XOR PAR_TYP, computed over the latched word; then go to STOP.
- STOP:
  - TX_OUT=1 for one bit, or two bits when STOP2 is latched.
  - At the end: if FIFO non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- busy is registered:
  - Goes high on the same edge TX_OUT first goes low.
  - Stays high through the final stop bit.
  - Falls on the edge the FSM enters IDLE.
- Latency: a word accepted on edge t into an empty FIFO while IDLE is popped on edge t+1; TX_OUT falls on edge t+2.
- Frame length in CLK cycles = P × (1 + DATA_WIDTH + PAR_EN + 1 + STOP2).
- No glitches on TX_OUT: it is driven directly from a flop.

Test Plan:
- Reset, then DATA_WIDTH=8, PRESCALE=4, PAR_EN=0, STOP2=0, send 0xA5 -> TX_OUT low at t+2. Bits 1,0,1,0,0,1,0,1 follow, each lasting 4 cycles, then 4 high cycles. busy high for 40 cycles.
- PAR_EN=1: send 0x07 with PAR_TYP=0 -> parity bit 1; send 0x07 with PAR_TYP=1 -> parity bit 0. Frame = 11 bits.
- STOP2=1, PRESCALE=0 -> bit period is 1 cycle; frame is 11 cycles with two trailing high bits.
- Push 5 words with Data_Valid held high and FIFO_DEPTH=4 -> 4 accepted immediately; Data_Ready drops at fifo_count=4. The fifth word is accepted after the first pop. All frames are sent back-to-back with no idle bit between the stop bit and the next start bit.
- Change PAR_EN and PRESCALE mid-frame -> current frame unaffected; next frame uses the new values.
- Assert RST during DATA bit 3 with 2 words buffered -> next edge: TX_OUT=1, busy=0, fifo_count=0. Nothing is transmitted afterwards.
